// File: rtl/rd_byte_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rd_byte_packer_pkg
//  Description : Shared definitions for the read byte packer: FSM state
//                encoding and beat-geometry helpers (STRB, STRB_LOG2).
//  Revision    : 1.0 - initial release
// ============================================================================
package rd_byte_packer_pkg;

    // Packer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2
    } pk_state_e;

    // Number of byte lanes in one beat
    function automatic int calc_strb(input int data_width);
        return data_width / 8;
    endfunction

    // Bits needed to index a byte lane
    function automatic int calc_strb_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Width able to hold a byte count 0..2*STRB-1 (residual + new beat)
    function automatic int calc_cnt_w(input int data_width);
        return $clog2(data_width / 8) + 1;
    endfunction

endpackage : rd_byte_packer_pkg
`default_nettype wire

// File: rtl/rd_byte_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rd_byte_packer_if
//  Description : Control, upstream beat and SRAM write bus of the packer.
//                slave = packer side, master = driver/monitor side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rd_byte_packer_if #(
    parameter int AXI_DATA_WIDTH      = 32,
    parameter int TRAN_BYTE_NUM_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH     = 32
) ();
    import rd_byte_packer_pkg::*;

    localparam int STRB = calc_strb(AXI_DATA_WIDTH);

    logic                           pk_start_i;
    logic [TRAN_BYTE_NUM_WIDTH-1:0] pk_total_byte_num_i;
    logic [SRAM_ADDR_WIDTH-1:0]     pk_sram_base_i;
    logic [STRB-1:0]                in_strb_i;
    logic [AXI_DATA_WIDTH-1:0]      in_data_i;
    logic                           sram_wr_en_o;
    logic [SRAM_ADDR_WIDTH-1:0]     sram_addr_o;
    logic [AXI_DATA_WIDTH-1:0]      sram_wdata_o;
    logic [STRB-1:0]                sram_wbe_o;
    logic                           pk_busy_o;
    logic                           pk_done_o;
    logic                           pk_error_o;

    modport master (
        output pk_start_i, pk_total_byte_num_i, pk_sram_base_i, in_strb_i, in_data_i,
        input  sram_wr_en_o, sram_addr_o, sram_wdata_o, sram_wbe_o,
        input  pk_busy_o, pk_done_o, pk_error_o
    );

    modport slave (
        input  pk_start_i, pk_total_byte_num_i, pk_sram_base_i, in_strb_i, in_data_i,
        output sram_wr_en_o, sram_addr_o, sram_wdata_o, sram_wbe_o,
        output pk_busy_o, pk_done_o, pk_error_o
    );

endinterface : rd_byte_packer_if
`default_nettype wire

// File: rtl/rd_byte_extract.sv
`default_nettype none
// ============================================================================
//  Module      : rd_byte_extract
//  Description : Combinational beat decoder: from a byte strobe derive the
//                valid byte count, lowest valid lane, contiguity flag, and
//                the beat data shifted so the first valid byte sits in lane 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_byte_extract
    import rd_byte_packer_pkg::*;
#(
    parameter  int AXI_DATA_WIDTH = 32,
    localparam int STRB           = calc_strb(AXI_DATA_WIDTH),
    localparam int CNT_W          = calc_cnt_w(AXI_DATA_WIDTH)
) (
    input  wire logic [STRB-1:0]           strb_i,
    input  wire logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic      [CNT_W-1:0]          byte_cnt_o,
    output logic      [CNT_W-1:0]          low_idx_o,
    output logic                           contig_o,
    output logic      [AXI_DATA_WIDTH-1:0] shifted_o
);

    logic [STRB-1:0] w_norm;

    // Popcount and lowest-set-lane search, then normalise and test for a single run of ones
    always_comb begin
        byte_cnt_o = '0;
        low_idx_o  = '0;
        for (int k = STRB - 1; k >= 0; k--) begin
            if (strb_i[k]) begin
                low_idx_o  = CNT_W'(k);
                byte_cnt_o = byte_cnt_o + CNT_W'(1);
            end
        end
        w_norm    = strb_i >> low_idx_o;
        // A run of ones starting at bit 0 has no bit in common with itself + 1
        contig_o  = (strb_i != '0) && ((w_norm & (w_norm + STRB'(1))) == '0);
        shifted_o = data_i >> {low_idx_o, 3'b000};
    end

endmodule : rd_byte_extract
`default_nettype wire

// File: rtl/rd_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rd_byte_packer
//  Description : Packs byte-strobed upstream beats into contiguous,
//                byte-0-aligned SRAM words with a one-cycle write latency,
//                flushing any partial residual word at end of transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_byte_packer
    import rd_byte_packer_pkg::*;
#(
    parameter int AXI_DATA_WIDTH      = 32,
    parameter int TRAN_BYTE_NUM_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH     = 32
) (
    input wire logic         clk,
    input wire logic         rst_n,
    rd_byte_packer_if.slave  bus
);

    localparam int STRB  = calc_strb(AXI_DATA_WIDTH);
    localparam int CNT_W = calc_cnt_w(AXI_DATA_WIDTH);
    localparam int ACC_W = TRAN_BYTE_NUM_WIDTH + 1;
    localparam int DW    = AXI_DATA_WIDTH;

    // Control state
    pk_state_e                  state_q, state_d;
    logic [DW-1:0]              res_q, res_d;         // residual bytes, lane 0 upward
    logic [CNT_W-1:0]           r_q, r_d;             // residual byte count
    logic [ACC_W-1:0]           acc_q, acc_d;         // bytes accepted so far
    logic [ACC_W-1:0]           total_q, total_d;     // bytes expected
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;       // next SRAM word address
    logic                       err_q, err_d;

    // Registered outputs
    logic                       wr_en_q, wr_en_d;
    logic [SRAM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DW-1:0]              wdata_q, wdata_d;
    logic [STRB-1:0]            wbe_q, wbe_d;
    logic                       done_q, done_d;
    logic                       busy_q;

    // Beat datapath
    logic [CNT_W-1:0]           w_n;
    logic [CNT_W-1:0]           w_o;
    logic                       w_contig;
    logic [DW-1:0]              w_shifted;
    logic [ACC_W-1:0]           w_remain;
    logic                       w_over;
    logic [CNT_W-1:0]           w_n_eff;
    logic [DW-1:0]              w_masked;
    logic [2*DW-1:0]            w_comb;
    logic [CNT_W-1:0]           w_sum;
    logic [STRB-1:0]            w_flush_be;

    rd_byte_extract #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_extract (
        .strb_i     (bus.in_strb_i),
        .data_i     (bus.in_data_i),
        .byte_cnt_o (w_n),
        .low_idx_o  (w_o),
        .contig_o   (w_contig),
        .shifted_o  (w_shifted)
    );

    // Clip the beat to the bytes still owed and splice it above the residual
    always_comb begin
        w_remain = total_q - acc_q;
        w_over   = ACC_W'(w_n) > w_remain;
        w_n_eff  = w_over ? CNT_W'(w_remain) : w_n;
        w_masked = '0;
        for (int k = 0; k < STRB; k++) begin
            if (CNT_W'(k) < w_n_eff) begin
                w_masked[8*k +: 8] = w_shifted[8*k +: 8];
            end
        end
        w_comb     = {{DW{1'b0}}, res_q} | ({{DW{1'b0}}, w_masked} << {r_q, 3'b000});
        w_sum      = r_q + w_n_eff;
        w_flush_be = '0;
        for (int k = 0; k < STRB; k++) begin
            w_flush_be[k] = (CNT_W'(k) < r_q);
        end
    end

    // Next-state and write-generation logic; a start pulse overrides every state
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        r_d     = r_q;
        acc_d   = acc_q;
        total_d = total_q;
        addr_d  = addr_q;
        err_d   = err_q;
        wr_en_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wbe_d   = '0;
        done_d  = 1'b0;

        if (bus.pk_start_i) begin
            res_d   = '0;
            r_d     = '0;
            acc_d   = '0;
            total_d = ACC_W'(bus.pk_total_byte_num_i);
            addr_d  = bus.pk_sram_base_i;
            err_d   = 1'b0;
            if (bus.pk_total_byte_num_i == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_PACK;
            end
        end else begin
            case (state_q)
                ST_PACK: begin
                    if (bus.in_strb_i != '0) begin
                        if (!w_contig) begin
                            err_d = 1'b1;
                        end else begin
                            if (w_over) begin
                                err_d = 1'b1;
                            end
                            acc_d = acc_q + ACC_W'(w_n_eff);
                            if (w_sum >= CNT_W'(STRB)) begin
                                wr_en_d = 1'b1;
                                wbe_d   = '1;
                                waddr_d = addr_q;
                                wdata_d = w_comb[DW-1:0];
                                addr_d  = addr_q + SRAM_ADDR_WIDTH'(1);
                                res_d   = w_comb[2*DW-1:DW];
                                r_d     = w_sum - CNT_W'(STRB);
                            end else begin
                                res_d   = w_comb[DW-1:0];
                                r_d     = w_sum;
                            end
                            if (acc_d == total_q) begin
                                if (r_d != '0) begin
                                    state_d = ST_FLUSH;
                                end else begin
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    // Beats arriving here are ignored; only the residual is written
                    wr_en_d = 1'b1;
                    wbe_d   = w_flush_be;
                    waddr_d = addr_q;
                    for (int k = 0; k < STRB; k++) begin
                        wdata_d[8*k +: 8] = w_flush_be[k] ? res_q[8*k +: 8] : 8'h00;
                    end
                    addr_d  = addr_q + SRAM_ADDR_WIDTH'(1);
                    res_d   = '0;
                    r_d     = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    // IDLE: beats are ignored without error
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            total_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            res_q   <= res_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            total_q <= total_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wbe_q   <= wbe_d;
            done_q  <= done_d;
            // Busy drops in the same cycle as the final write and done pulse
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.sram_wr_en_o = wr_en_q;
    assign bus.sram_addr_o  = waddr_q;
    assign bus.sram_wdata_o = wdata_q;
    assign bus.sram_wbe_o   = wbe_q;
    assign bus.pk_busy_o    = busy_q;
    assign bus.pk_done_o    = done_q;
    assign bus.pk_error_o   = err_q;

endmodule : rd_byte_packer
`default_nettype wire

// File: doc/rd_byte_packer.md
RD_BYTE_PACKER -- requirements
Module: rd_byte_packer

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32: input beat width in bits, a multiple of 8; STRB = AXI_DATA_WIDTH/8.
REQ-002 SHALL have parameter TRAN_BYTE_NUM_WIDTH, default 16: width of the transfer byte count.
REQ-003 SHALL have parameter SRAM_ADDR_WIDTH, default 32: SRAM word address width.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 pk_start_i  input  1  one-cycle pulse that starts a transfer.
REQ-007 pk_total_byte_num_i  input  TRAN_BYTE_NUM_WIDTH  payload byte count, sampled on pk_start_i.
REQ-008 pk_sram_base_i  input  SRAM_ADDR_WIDTH  first SRAM word address, sampled on pk_start_i.
REQ-009 in_strb_i  input  STRB  upstream byte-valid mask; a nonzero value marks a beat.
REQ-010 in_data_i  input  AXI_DATA_WIDTH  upstream beat data; byte k is bits 8k+7:8k.
REQ-011 sram_wr_en_o  output  1  SRAM write strobe.
REQ-012 sram_addr_o  output  SRAM_ADDR_WIDTH  SRAM word address.
REQ-013 sram_wdata_o  output  AXI_DATA_WIDTH  packed write data.
REQ-014 sram_wbe_o  output  STRB  SRAM byte enables.
REQ-015 pk_busy_o  output  1  transfer in progress.
REQ-016 pk_done_o  output  1  one-cycle pulse at end of transfer.
REQ-017 pk_error_o  output  1  sticky error flag.

Function
REQ-018 SHALL compact byte-strobed beats, whose first and last beats may be partial, into contiguous byte-0-aligned SRAM words.
REQ-019 Input has no backpressure: SHALL accept one beat per cycle, every cycle, whenever in_strb_i != 0 and state is PACK.
REQ-020 Per beat: n = popcount(in_strb_i); o = index of lowest set bit; valid bytes = in_data_i bytes o..o+n-1.
REQ-021 Beat bytes SHALL be appended above the r residual bytes (0 <= r < STRB), keeping byte order.
REQ-022 If r+n >= STRB: SHALL write the low STRB bytes with sram_wbe_o all ones, and keep the remaining r+n-STRB bytes as the new residual.
REQ-023 If r+n < STRB: SHALL only accumulate; no write that cycle.
REQ-024 Write latency SHALL be exactly 1 cycle: registered sram_* outputs are valid the cycle after the completing beat.
REQ-025 sram_addr_o SHALL start at pk_sram_base_i and increment by 1 after each write, wrapping modulo 2^SRAM_ADDR_WIDTH.
REQ-026 SHALL keep a byte-accepted counter of TRAN_BYTE_NUM_WIDTH+1 bits.
REQ-027 Once accepted == total: if r > 0, SHALL go to FLUSH and write the residual with sram_wbe_o = (1<<r)-1 and zeros in the unused bytes; if r = 0, SHALL finish.
REQ-028 If the final beat both completes a word and leaves a residual: full word in cycle N+1, flush word in cycle N+2.
REQ-029 pk_done_o SHALL pulse in the cycle of the last write; pk_busy_o SHALL fall in that same cycle.
REQ-030 Total = 0: SHALL perform no write, pulse pk_done_o the cycle after start, and never leave busy asserted.
REQ-031 State machine IDLE -> (start) PACK -> (total reached, r>0) FLUSH -> IDLE; PACK -> (total reached, r=0) IDLE.
REQ-032 pk_start_i in any state SHALL discard the residual, cancel any pending flush, reload all counters and enter PACK (IDLE only for total = 0).
REQ-033 Non-contiguous in_strb_i SHALL set pk_error_o; that beat is dropped and the counter is not advanced.
REQ-034 Bytes beyond total SHALL be dropped and SHALL set pk_error_o.
REQ-035 Beats arriving in IDLE or FLUSH SHALL be ignored with no error.
REQ-036 pk_error_o SHALL clear only on pk_start_i.
REQ-037 sram_wr_en_o and sram_wbe_o SHALL be 0 in every cycle without a write.

Reset
REQ-038 On rst_n low, all outputs, the residual, the counters and the state (IDLE) SHALL clear to 0 immediately; an in-flight transfer is abandoned with no done pulse.
REQ-039 After reset release, no write SHALL occur before a pk_start_i.

Structure
REQ-040 Shared package SHALL hold the state encoding (IDLE/PACK/FLUSH) and the STRB/STRB_LOG2 derivation.
REQ-041 One sub-module, rd_byte_extract, SHALL be combinational: strobe -> n, o, contiguity flag, right-shifted bytes.

Verification
REQ-042 Start total=10, base=0x40; beats strb 4'b1100 data 0xBBAA0000, 4'b1111 data 0x44332211, 4'b1111 data 0x88776655 -> writes: addr 0x40 data 0x2211BBAA wbe 4'hF; addr 0x41 data 0x66554433 wbe 4'hF; addr 0x42 data 0x00008877 wbe 4'h3; done pulses with the third write.
REQ-043 Total=8, beats 0x03020100 and 0x07060504 with full strb on back-to-back cycles -> two writes one cycle after each beat, no FLUSH, done with the second write.
REQ-044 Total=0 -> no write; done pulses 1 cycle after start; busy is never asserted.
REQ-045 strb 4'b1010 mid-transfer -> pk_error_o = 1, beat dropped; error clears on the next pk_start_i.
REQ-046 rst_n asserted while r=2 -> all outputs 0 at once, no flush.
REQ-047 pk_start_i during PACK with r=3 -> residual discarded, new transfer starts at the new base address.
